riscof_obi_data_responder: RTL and testbench

- OBI data-side responder for the RISCOF compliance bench. It is the memory-and-peripheral end of the core's data_req/gnt/rvalid interface.
- Serves word reads and byte-enabled writes from an internal RAM and decodes an exit/status register.
- Inserts configurable grant stalls and response latency so the core's LSU sees realistic back-pressure.
- Keeps up to FIFO_DEPTH transactions outstanding, with responses returned strictly in order.

---
 rtl/riscof_obi_data_responder.sv | 134 +++++++++++++
 tb/tb_riscof_obi_data_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscof_obi_data_responder.sv
// OBI data-side responder for the RISCOF bench: word RAM with byte-enabled writes, an exit/status
// register, optional periodic grant stalls and an in-order response FIFO with fixed latency.
module riscof_obi_data_responder #(
    parameter int          RAM_ADDR_WIDTH = 16,
    parameter int          FIFO_DEPTH     = 4,
    parameter int          RVALID_LATENCY = 1,
    parameter int          STALL_PERIOD   = 0,
    parameter logic [31:0] EXIT_ADDR      = 32'h2000_0004
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_i,
    output logic                              gnt_o,
    input  logic [31:0]                       addr_i,
    input  logic                              we_i,
    input  logic [3:0]                        be_i,
    input  logic [31:0]                       wdata_i,
    output logic                              rvalid_o,
    output logic [31:0]                       rdata_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding_o,
    output logic                              tests_passed_o,
    output logic                              tests_failed_o,
    output logic                              exit_valid_o,
    output logic [31:0]                       exit_value_o
);
    localparam int WORDS = 2 ** (RAM_ADDR_WIDTH - 2);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int DW    = (RVALID_LATENCY > 1) ? $clog2(RVALID_LATENCY) : 1;
    localparam int SW    = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_PERIOD == 0) ? 0 : STALL_PERIOD - 1);
    localparam logic [DW-1:0] DLY_INIT   = DW'(RVALID_LATENCY - 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    logic [31:0]   mem_q  [WORDS];
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [DW-1:0] dly_q  [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          exit_valid_q, passed_q, failed_q;
    logic [31:0]   exit_value_q;

    logic                      stall, accept, ram_hit, exit_hit;
    logic                      head_ready, bypass, push, pop;
    logic [RAM_ADDR_WIDTH-3:0] widx;
    logic [31:0]               acc_rdata;

    assign stall   = (STALL_PERIOD != 0) && (cnt_q == STALL_LAST);
    assign gnt_o   = req_i && !rst_i && !stall && (count_q < DEPTH_C);
    assign accept  = req_i && gnt_o;
    assign ram_hit = (addr_i >> RAM_ADDR_WIDTH) == 32'd0;
    assign widx    = addr_i[RAM_ADDR_WIDTH-1:2];
    assign exit_hit = accept && we_i && (addr_i == EXIT_ADDR) && !exit_valid_q;

    // Read data is sampled at the accepting edge; earlier writes already landed in mem_q.
    assign acc_rdata = (!we_i && ram_hit) ? mem_q[widx] : 32'd0;

    // An entry may leave when its delay reaches 0 across this edge; with unit latency a push
    // into an empty FIFO goes straight to the output register so rvalid follows the grant.
    assign head_ready = (count_q != '0) && (dly_q[rd_ptr_q] <= DW'(1));
    assign bypass     = accept && (count_q == '0) && (RVALID_LATENCY == 1);
    assign push       = accept && !bypass;
    assign pop        = head_ready || bypass;

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(head_ready);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = head_ready ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = (cnt_q == STALL_LAST) ? '0 : cnt_q + SW'(1);
        rvalid_d = pop;
        rdata_d  = rdata_q;
        if (head_ready)  rdata_d = data_q[rd_ptr_q];
        else if (bypass) rdata_d = acc_rdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            exit_valid_q <= 1'b0;
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_value_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            if (exit_hit) begin
                exit_valid_q <= 1'b1;
                exit_value_q <= wdata_i;
                passed_q     <= (wdata_i == 32'd0);
                failed_q     <= (wdata_i != 32'd0);
            end
        end
    end

    // Delays saturate at 0 so a blocked head leaves later entries ready to follow back-to-back.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (dly_q[i] != '0) dly_q[i] <= dly_q[i] - DW'(1);
        end
        if (push) begin
            data_q[wr_ptr_q] <= acc_rdata;
            dly_q[wr_ptr_q]  <= DLY_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[widx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rvalid_o       = rvalid_q;
    assign rdata_o        = rdata_q;
    assign outstanding_o  = count_q;
    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;
endmodule

// File: tb/tb_riscof_obi_data_responder.sv
// Bench for riscof_obi_data_responder: three instances (latency 1 / latency 8 / stall period 3)
// driven from per-instance request queues and checked against a due-time response model.
module tb_riscof_obi_data_responder;
    localparam logic [31:0] EXIT = 32'h2000_0004;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } op_t;
    typedef struct { logic [31:0] data; int due; } ex_t;

    logic        clk, rst;
    logic        req [3], we [3], gnt [3], rv [3], tp [3], tf [3], ev [3];
    logic [31:0] addr [3], wdata [3], rdata [3], evl [3];
    logic [3:0]  be [3];
    logic [2:0]  outst [3];

    int LATP [3] = '{1, 8, 2};
    int STP  [3] = '{0, 0, 3};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscof_obi_data_responder #(
            .RAM_ADDR_WIDTH(16), .FIFO_DEPTH(4),
            .RVALID_LATENCY(g == 1 ? 8 : (g == 2 ? 2 : 1)),
            .STALL_PERIOD(g == 2 ? 3 : 0), .EXIT_ADDR(32'h2000_0004)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .req_i(req[g]), .gnt_o(gnt[g]), .addr_i(addr[g]),
            .we_i(we[g]), .be_i(be[g]), .wdata_i(wdata[g]), .rvalid_o(rv[g]), .rdata_o(rdata[g]),
            .outstanding_o(outst[g]), .tests_passed_o(tp[g]), .tests_failed_o(tf[g]),
            .exit_valid_o(ev[g]), .exit_value_o(evl[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    op_t         sq [3][$];
    ex_t         eq [3][$];
    logic [31:0] mm [3][129];
    logic        mev [3];
    logic [31:0] mval [3], lastrd [3];
    int          t [3], gcnt [3];
    int          now = 0, bubble = 0, total = 0, passed = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h0000_FFFC) return 128;
        return int'(w >> 2);
    endfunction

    task automatic enq(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d);
        op_t o;
        o.addr = a; o.we = w; o.be = b; o.wdata = d;
        sq[k].push_back(o);
    endtask

    task automatic model_accept(input int k);
        op_t         o;
        ex_t         e;
        logic [31:0] rd;
        o  = sq[k].pop_front();
        rd = 32'd0;
        if (o.we) begin
            if (o.addr < 32'h1_0000) begin
                for (int b = 0; b < 4; b++)
                    if (o.be[b]) mm[k][widx(o.addr)][8*b +: 8] = o.wdata[8*b +: 8];
            end else if (o.addr == EXIT && !mev[k]) begin
                mev[k] = 1'b1; mval[k] = o.wdata;
            end
        end else if (o.addr < 32'h1_0000) begin
            rd = mm[k][widx(o.addr)];
        end
        e.data = rd;
        e.due  = now + LATP[k];
        if (eq[k].size() > 0 && eq[k][$].due >= e.due) e.due = eq[k][$].due + 1;
        eq[k].push_back(e);
    endtask

    task automatic model_step(input int k);
        int   nout;
        logic eg, erv;
        nout = 0;
        foreach (eq[k][i]) if (eq[k][i].due > now) nout++;
        eg = req[k] && !rst && !(STP[k] != 0 && (t[k] % STP[k]) == STP[k] - 1) && nout < 4;
        chk("gnt", k, gnt[k], eg);
        chk("outstanding", k, outst[k], nout);
        if (gnt[k]) gcnt[k]++;
        erv = eq[k].size() > 0 && eq[k][0].due == now;
        chk("rvalid", k, rv[k], erv);
        if (erv) begin
            chk("rdata", k, rdata[k], eq[k][0].data);
            lastrd[k] = rdata[k];
            void'(eq[k].pop_front());
        end else if (eq[k].size() > 0 && eq[k][0].due < now) begin
            void'(eq[k].pop_front());
        end
        chk("exit_valid", k, ev[k], mev[k]);
        chk("exit_value", k, evl[k], mval[k]);
        chk("passed", k, tp[k], mev[k] && mval[k] == 0);
        chk("failed", k, tf[k], mev[k] && mval[k] != 0);
        if (rst) begin
            eq[k].delete(); mev[k] = 1'b0; mval[k] = '0; t[k] = 0;
        end else begin
            if (eg) model_accept(k);
            t[k]++;
        end
    endtask

    task automatic cyc();
        for (int k = 0; k < 3; k++) begin
            if (sq[k].size() > 0 && $urandom_range(99) >= bubble) begin
                req[k] = 1'b1; addr[k] = sq[k][0].addr; we[k] = sq[k][0].we;
                be[k] = sq[k][0].be; wdata[k] = sq[k][0].wdata;
            end else begin
                req[k] = 1'b0;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        now++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size() + eq[0].size() + eq[1].size()
                + eq[2].size()) > 0 && n < budget) begin
            cyc();
            n++;
        end
        chk("drain_in_budget", 0, 32'(n < budget), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b1; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
            mev[k] = 1'b0; mval[k] = '0; lastrd[k] = '0; t[k] = 0; gcnt[k] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt", k, gnt[k], 1'b0);
            chk("rst_rvalid", k, rv[k], 1'b0);
            chk("rst_rdata", k, rdata[k], 32'd0);
            chk("rst_outstanding", k, outst[k], 3'd0);
            chk("rst_passed", k, tp[k], 1'b0);
            chk("rst_failed", k, tf[k], 1'b0);
            chk("rst_exit_valid", k, ev[k], 1'b0);
            chk("rst_exit_value", k, evl[k], 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload every word the bench will read so expectations are always defined.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 128; i++) enq(k, i * 4, 1'b1, 4'hF, $urandom);
            enq(k, 32'h0000_FFFC, 1'b1, 4'hF, $urandom);
        end
        drain(2000);

        enq(0, 32'h100, 1'b1, 4'hF, 32'hAABB_CCDD);
        enq(0, 32'h100, 1'b0, 4'h0, 32'h0);
        drain(50);
        chk("raw_readback", 0, lastrd[0], 32'hAABB_CCDD);
        enq(0, 32'h40, 1'b1, 4'hF, 32'h1122_3344);
        enq(0, 32'h40, 1'b1, 4'b0101, 32'hFFFF_FFFF);
        enq(0, 32'h40, 1'b0, 4'h0, 32'h0);
        drain(50);
        chk("be_merge", 0, lastrd[0], 32'h11FF_33FF);

        for (int i = 0; i < 5; i++) enq(1, i * 4, 1'b0, 4'h0, 32'h0);
        repeat (4) cyc();
        chk("full_outstanding", 1, outst[1], 3'd4);
        drain(100);

        enq(0, EXIT, 1'b1, 4'h0, 32'd0);
        enq(0, EXIT, 1'b1, 4'hF, 32'd5);
        enq(1, EXIT, 1'b1, 4'hF, 32'd5);
        drain(100);
        chk("exit0_passed", 0, tp[0], 1'b1);
        chk("exit0_failed", 0, tf[0], 1'b0);
        chk("exit0_value", 0, evl[0], 32'd0);
        chk("exit1_failed", 1, tf[1], 1'b1);
        chk("exit1_value", 1, evl[1], 32'd5);

        for (int i = 0; i < 3; i++) enq(1, i * 4, 1'b0, 4'h0, 32'h0);
        repeat (3) cyc();
        chk("pre_rst_outstanding", 1, outst[1], 3'd3);
        for (int i = 0; i < 40; i++) enq(2, (i % 8) * 4, 1'b0, 4'h0, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("post_rst_outstanding", 1, outst[1], 3'd0);
        chk("post_rst_exit_valid", 0, ev[0], 1'b0);
        chk("post_rst_failed", 1, tf[1], 1'b0);
        gcnt[2] = 0;
        repeat (30) cyc();
        chk("stall_grants_30", 2, gcnt[2], 32'd20);
        drain(200);

        bubble = 30;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 300; i++) begin
                logic [31:0] a;
                int          r;
                r = $urandom_range(9);
                if (r <= 6)      a = ($urandom_range(127) << 2) | $urandom_range(3);
                else if (r == 7) a = 32'h0000_FFFC | $urandom_range(3);
                else if (r == 8) a = 32'h0001_0000 + ($urandom_range(255) << 2);
                else             a = ($urandom_range(1) == 1) ? EXIT : 32'h2000_0000;
                enq(k, a, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
            end
        end
        drain(5000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
